// File: rtl/bin2dis.sv
// Sequential 20-bit binary to six-digit display-code converter (double dabble, one bit per clock).
// Optional leading-zero blanking on dis1..dis5 is enabled by defining BIN2DIS_LZB_EN.
module bin2dis #(
    parameter int          WIDTH   = 20,
    parameter int unsigned MAX_VAL = 999_999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [3:0]       dis1,
    output logic [3:0]       dis2,
    output logic [3:0]       dis3,
    output logic [3:0]       dis4,
    output logic [3:0]       dis5,
    output logic [3:0]       dis6
);

    localparam logic [WIDTH-1:0] MAX_VEC   = MAX_VAL[WIDTH-1:0];
    localparam logic [3:0]       CODE_DASH = 4'd10;
    localparam logic [3:0]       CODE_DARK = 4'd11;
    localparam logic [4:0]       LAST_BIT  = 5'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FORMAT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [23:0]        dis_q, dis_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic [23:0]        bcd_q, bcd_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [23:0]        bcd_adj;

    // Independent 4-bit add-3 per nibble; no carry crosses a digit boundary.
    function automatic logic [23:0] add3_all(input logic [23:0] b);
        logic [23:0] r;
        logic [3:0]  nib;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            nib = b[i*4 +: 4];
            r[i*4 +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
        return r;
    endfunction

    function automatic logic [23:0] format_digits(input logic [23:0] b, input logic ovf);
        logic [23:0] r;
`ifdef BIN2DIS_LZB_EN
        logic        leading;
`endif
        if (ovf) begin
            r = {6{CODE_DASH}};
        end else begin
            r = b;
`ifdef BIN2DIS_LZB_EN
            // Walk from dis1 (bits 23:20) toward dis5; dis6 is always shown.
            leading = 1'b1;
            for (int i = 5; i >= 1; i--) begin
                if (leading && (b[i*4 +: 4] == 4'd0)) begin
                    r[i*4 +: 4] = CODE_DARK;
                end else begin
                    leading = 1'b0;
                end
            end
`endif
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dis_d   = dis_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        bcd_adj = add3_all(bcd_q);

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    bin_d   = value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = (value > MAX_VEC);
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = {bcd_adj[22:0], bin_q[WIDTH-1]};
                bin_d = {bin_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_BIT) begin
                    state_d = FORMAT;
                end
            end
            FORMAT: begin
                // busy stays high through the done cycle; it drops back in IDLE.
                dis_d   = format_digits(bcd_q, ovf_q);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        bin_q <= bin_d;
        bcd_q <= bcd_d;
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dis_q   <= {6{CODE_DARK}};
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dis_q   <= dis_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dis1 = dis_q[23:20];
    assign dis2 = dis_q[19:16];
    assign dis3 = dis_q[15:12];
    assign dis4 = dis_q[11:8];
    assign dis5 = dis_q[7:4];
    assign dis6 = dis_q[3:0];

endmodule

// File: tb/tb_bin2dis.sv
// Randomized self-checking bench for bin2dis against an arithmetic decimal-digit model.
module tb_bin2dis;

    logic        clk;
    logic        rst;
    logic        start;
    logic [19:0] value;
    logic        busy;
    logic        done;
    logic [3:0]  dis1, dis2, dis3, dis4, dis5, dis6;

    int n_chk;
    int n_fail;
    logic [23:0] cur_dis;

    bin2dis dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .value (value),
        .busy  (busy),
        .done  (done),
        .dis1  (dis1),
        .dis2  (dis2),
        .dis3  (dis3),
        .dis4  (dis4),
        .dis5  (dis5),
        .dis6  (dis6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [23:0] obs_dis();
        return {dis1, dis2, dis3, dis4, dis5, dis6};
    endfunction

    // Decimal digits by division; blanking mirrors the display rules, not the hardware.
    function automatic logic [23:0] model(input int unsigned v);
        int unsigned pw [6] = '{100000, 10000, 1000, 100, 10, 1};
        int unsigned d;
        logic [23:0] r;
        bit          leading;
        r = '0;
        leading = 1'b1;
        if (v > 999_999) return {6{4'd10}};
        for (int i = 0; i < 6; i++) begin
            d = (v / pw[i]) % 10;
            r[(5-i)*4 +: 4] = d[3:0];
`ifdef BIN2DIS_LZB_EN
            if (i < 5 && leading && d == 0) r[(5-i)*4 +: 4] = 4'd11;
            else leading = 1'b0;
`endif
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full conversion with edge-by-edge checks; optionally disturbs value/start mid-flight.
    task automatic run(input int unsigned v, input bit disturb);
        logic [23:0] exp;
        exp   = model(v);
        value = v[19:0];
        start = 1'b1;
        step();
        chk("accept_busy", busy, 1);
        chk("accept_done", done, 0);
        start = 1'b0;
        value = 20'($urandom);
        for (int c = 1; c <= 20; c++) begin
            step();
            chk("shift_done", done, 0);
            chk("shift_busy", busy, 1);
            chk("shift_hold", obs_dis(), cur_dis);
            if (disturb && c == 3) value = 20'($urandom);
            if (disturb && c == 4) begin
                start = 1'b1;
                value = 20'd777;
            end
            if (disturb && c == 5) start = 1'b0;
        end
        step();
        chk("fmt_done", done, 1);
        chk("fmt_busy", busy, 1);
        chk($sformatf("digits_%0d", v), obs_dis(), exp);
        cur_dis = exp;
        step();
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("post_hold", obs_dis(), cur_dis);
    endtask

    initial begin
        int unsigned directed [7] = '{123_456, 42, 0, 100_005, 999_999, 1_000_000, 1_048_575};
        int done_cnt;
        int done_at [$];
        n_chk   = 0;
        n_fail  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        value   = '0;
        cur_dis = {6{4'd11}};

        repeat (3) step();
        rst = 1'b0;
        chk("rst_dis", obs_dis(), {6{4'd11}});
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        done_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (done) done_cnt++;
        end
        chk("idle_no_done", done_cnt, 0);

        foreach (directed[i]) run(directed[i], 1'b0);
        for (int i = 0; i < 30; i++) begin
            case (i % 3)
                0: run($urandom_range(0, 1_048_575), 1'b0);
                1: run($urandom_range(0, 999), 1'b0);
                default: run($urandom_range(990_000, 1_010_000), 1'b0);
            endcase
        end

        run(555, 1'b1);

        // Continuous start: acceptances at 0, 22, 44; start dropped after 44.
        value = 20'd555;
        start = 1'b1;
        for (int i = 0; i <= 70; i++) begin
            step();
            if (i == 44) start = 1'b0;
            if (done) begin
                done_at.push_back(i);
                chk("b2b_digits", obs_dis(), model(555));
            end
            if (i == 0 || i == 22 || i == 44) chk("b2b_busy", busy, 1);
        end
        chk("b2b_count", done_at.size(), 3);
        if (done_at.size() == 3) begin
            chk("b2b_t0", done_at[0], 21);
            chk("b2b_t1", done_at[1], 43);
            chk("b2b_t2", done_at[2], 65);
        end
        chk("b2b_idle_busy", busy, 0);
        cur_dis = model(555);

        // Reset in the middle of a conversion, with start asserted alongside rst.
        value = 20'd654_321;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        rst   = 1'b1;
        start = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        cur_dis = {6{4'd11}};
        chk("mid_rst_dis", obs_dis(), cur_dis);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (done || busy) done_cnt++;
        end
        chk("mid_rst_quiet", done_cnt, 0);
        run(654_321, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
